// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with centre sampling.
//
// Detects a start bit on the synchronised serial line, samples each bit at its
// centre using an OVS-cycle tick counter and shifts in DATA_W data bits LSB
// first, followed by an optional parity bit and STOP_BITS stop bits. Completed
// words are presented with a one-cycle store pulse, followed one cycle later by
// a clr_rx_start pulse.
//
// Optional feature: define UART_RX_MAJORITY_EN to take every sample as the
// 2-of-3 majority of three consecutive synchronised values around the centre.
// This delays every sampling decision (and store/clr_rx_start) by one cycle.
//
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-low reset
//   rx_start     in   receive enable, examined only while idle
//   rxd          in   serial line (idles high, asynchronous to clk)
//   rx_data      out  last received word
//   store        out  one-cycle pulse: rx_data and error flags valid
//   parity_err   out  parity mismatch in the last frame
//   frame_err    out  a stop bit was sampled low in the last frame
//   clr_rx_start out  one-cycle pulse asking for rx_start to be cleared
//   busy         out  high whenever the receiver is not idle
module uart_rx_param #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned OVS         = 16,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_start,
    input  logic              rxd,
    output logic [DATA_W-1:0] rx_data,
    output logic              store,
    output logic              parity_err,
    output logic              frame_err,
    output logic              clr_rx_start,
    output logic              busy
);

    localparam int unsigned P  = (PARITY_MODE != 0) ? 1 : 0;
    localparam int unsigned N  = 1 + DATA_W + P + STOP_BITS;
    localparam int unsigned TW = $clog2(OVS);
    localparam int unsigned BW = $clog2(N + 1);

`ifdef UART_RX_MAJORITY_EN
    // Decision taken one tick after the centre so all three votes are in.
    localparam logic [TW-1:0] StartHit = TW'(OVS / 2);
`else
    localparam logic [TW-1:0] StartHit = TW'(OVS / 2 - 1);
`endif
    localparam logic [TW-1:0] DataHit   = TW'(OVS - 1);
    localparam logic [BW-1:0] DataLast  = BW'(DATA_W - 1);
    localparam logic [BW-1:0] StopLast  = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StDone,
        StClear
    } state_t;

    state_t             state;
    logic               sync1;
    logic               rxs;
    logic               rxsPrev;
    logic [TW-1:0]      tickCnt;
    logic [BW-1:0]      bitCnt;
    logic [DATA_W-1:0]  shiftReg;
    logic               parErrInt;
    logic               frameErrInt;
    logic               sampleBit;
    logic               tickHit;
    logic               parExp;

`ifdef UART_RX_MAJORITY_EN
    logic rxsPrev2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxsPrev2 <= 1'b1;
        end else begin
            rxsPrev2 <= rxsPrev;
        end
    end

    // rxsPrev2/rxsPrev/rxs hold the line at centre-1, centre and centre+1.
    assign sampleBit = (rxsPrev2 & rxsPrev) | (rxsPrev2 & rxs) | (rxsPrev & rxs);
`else
    assign sampleBit = rxs;
`endif

    always_comb begin
        tickHit = (state == StStart) ? (tickCnt == StartHit) : (tickCnt == DataHit);
        parExp  = (PARITY_MODE == 2) ? ~(^shiftReg) : (^shiftReg);
    end

    assign busy = (state != StIdle);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= StIdle;
            sync1        <= 1'b1;
            rxs          <= 1'b1;
            rxsPrev      <= 1'b1;
            tickCnt      <= '0;
            bitCnt       <= '0;
            shiftReg     <= '0;
            parErrInt    <= 1'b0;
            frameErrInt  <= 1'b0;
            rx_data      <= '0;
            store        <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
            clr_rx_start <= 1'b0;
        end else begin
            sync1        <= rxd;
            rxs          <= sync1;
            rxsPrev      <= rxs;
            store        <= 1'b0;
            clr_rx_start <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (rx_start && rxsPrev && !rxs) begin
                        state       <= StStart;
                        tickCnt     <= '0;
                        parErrInt   <= 1'b0;
                        frameErrInt <= 1'b0;
                    end
                end

                StStart: begin
                    if (tickHit) begin
                        tickCnt <= '0;
                        bitCnt  <= '0;
                        // A high centre sample means the edge was a glitch.
                        state   <= sampleBit ? StIdle : StData;
                    end else begin
                        tickCnt <= tickCnt + 1'b1;
                    end
                end

                StData: begin
                    if (tickHit) begin
                        tickCnt  <= '0;
                        shiftReg <= {sampleBit, shiftReg[DATA_W-1:1]};
                        if (bitCnt == DataLast) begin
                            bitCnt <= '0;
                            state  <= (P != 0) ? StParity : StStop;
                        end else begin
                            bitCnt <= bitCnt + 1'b1;
                        end
                    end else begin
                        tickCnt <= tickCnt + 1'b1;
                    end
                end

                StParity: begin
                    if (tickHit) begin
                        tickCnt   <= '0;
                        bitCnt    <= '0;
                        parErrInt <= (sampleBit != parExp);
                        state     <= StStop;
                    end else begin
                        tickCnt <= tickCnt + 1'b1;
                    end
                end

                StStop: begin
                    if (tickHit) begin
                        tickCnt <= '0;
                        if (!sampleBit) begin
                            frameErrInt <= 1'b1;
                        end
                        if (bitCnt == StopLast) begin
                            // Results are loaded on the way into DONE so they
                            // are valid for the whole cycle store is high.
                            state      <= StDone;
                            rx_data    <= shiftReg;
                            parity_err <= parErrInt;
                            frame_err  <= frameErrInt | ~sampleBit;
                            store      <= 1'b1;
                        end else begin
                            bitCnt <= bitCnt + 1'b1;
                        end
                    end else begin
                        tickCnt <= tickCnt + 1'b1;
                    end
                end

                StDone: begin
                    clr_rx_start <= 1'b1;
                    state        <= StClear;
                end

                StClear: begin
                    state <= StIdle;
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: a default instance (8N1) and an instance
// with DATA_W=7, even parity. Frames are driven bit by bit; a negedge monitor
// records when store, clr_rx_start and busy are seen.
module tb_uart_rx_param;

    localparam int OVS = 16;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] rxStart;
    logic [1:0] rxd;
    logic [7:0] rxData0;
    logic [6:0] rxData1;
    logic [1:0] storeV, peV, feV, clrV, busyV;

    uart_rx_param dut0 (
        .clk          (clk),
        .rst          (rst),
        .rx_start     (rxStart[0]),
        .rxd          (rxd[0]),
        .rx_data      (rxData0),
        .store        (storeV[0]),
        .parity_err   (peV[0]),
        .frame_err    (feV[0]),
        .clr_rx_start (clrV[0]),
        .busy         (busyV[0])
    );

    uart_rx_param #(
        .DATA_W      (7),
        .OVS         (16),
        .PARITY_MODE (1),
        .STOP_BITS   (1)
    ) dut1 (
        .clk          (clk),
        .rst          (rst),
        .rx_start     (rxStart[1]),
        .rxd          (rxd[1]),
        .rx_data      (rxData1),
        .store        (storeV[1]),
        .parity_err   (peV[1]),
        .frame_err    (feV[1]),
        .clr_rx_start (clrV[1]),
        .busy         (busyV[1])
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: "cycle X" is the interval that ends at posedge number X.
    int         storeCnt[2], clrCnt[2], storeAt[2], clrAt[2];
    int         busyRise[2], busyFall[2], busyHi[2];
    int         overlap = 0;
    logic [1:0] busyPrev = 2'b00;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (storeV[i] === 1'b1) begin
                storeCnt[i]++;
                storeAt[i] = cyc + 1;
            end
            if (clrV[i] === 1'b1) begin
                clrCnt[i]++;
                clrAt[i] = cyc + 1;
            end
            if (storeV[i] === 1'b1 && clrV[i] === 1'b1) overlap++;
            if (busyV[i] === 1'b1) busyHi[i]++;
            if (busyV[i] === 1'b1 && busyPrev[i] !== 1'b1) busyRise[i] = cyc + 1;
            if (busyV[i] !== 1'b1 && busyPrev[i] === 1'b1) busyFall[i] = cyc + 1;
        end
        busyPrev = busyV;
    end

    int applied = 0;
    int errs    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] readData(input int sel);
        return (sel == 0) ? 32'(rxData0) : 32'(rxData1);
    endfunction

    function automatic logic [15:0] mkFrame(input logic [8:0] d, input int dw, input int hp,
                                            input logic pb, input logic sb);
        logic [15:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < dw; i++) f[1+i] = d[i];
        if (hp != 0) f[1+dw] = pb;
        f[1+dw+hp] = sb;
        return f;
    endfunction

    // Call #1 after a posedge. Value i is sampled by the DUT at posedge t0+i.
    task automatic sendWave(input int sel, input logic [15:0] bits, input int nbits,
                            input int glitchAt, input int stopAt, output int t0);
        int   total;
        logic v;
        total = nbits * OVS;
        if (stopAt < total) total = stopAt;
        t0 = cyc + 1;
        for (int i = 0; i < total; i++) begin
            v = bits[i / OVS];
            if (i == glitchAt) v = ~v;
            rxd[sel] = v;
            @(posedge clk);
            #1;
        end
        rxd[sel] = 1'b1;
    endtask

    typedef struct {
        int         sel;
        logic [8:0] data;
        logic       parBit;
        logic       stopBit;
        logic       rxStart;
        logic       expStore;
        logic [8:0] expData;
        logic       expFe;
        logic       expPe;
    } vec_t;

    vec_t vecs[8];
    vec_t v;
    int   t0, sel, dw, hp, sc0, cc0, bh0;

    task automatic checkReset(input string tag);
        check({tag, " rx_data"}, 32'(rxData0), 32'h0);
        check({tag, " store"}, 32'(storeV[0]), 32'h0);
        check({tag, " clr_rx_start"}, 32'(clrV[0]), 32'h0);
        check({tag, " parity_err"}, 32'(peV[0]), 32'h0);
        check({tag, " frame_err"}, 32'(feV[0]), 32'h0);
        check({tag, " busy"}, 32'(busyV[0]), 32'h0);
    endtask

    initial begin
        //         sel data     par   stop  rxst  store expData  fe    pe
        vecs[0] = '{0, 9'h0A5, 1'b0, 1'b1, 1'b1, 1'b1, 9'h0A5, 1'b0, 1'b0};
        vecs[1] = '{0, 9'h03C, 1'b0, 1'b0, 1'b1, 1'b1, 9'h03C, 1'b1, 1'b0};
        vecs[2] = '{0, 9'h05A, 1'b0, 1'b1, 1'b1, 1'b1, 9'h05A, 1'b0, 1'b0};
        vecs[3] = '{0, 9'h055, 1'b0, 1'b1, 1'b0, 1'b0, 9'h05A, 1'b0, 1'b0};
        vecs[4] = '{1, 9'h007, 1'b0, 1'b1, 1'b1, 1'b1, 9'h007, 1'b0, 1'b1};
        vecs[5] = '{1, 9'h007, 1'b1, 1'b1, 1'b1, 1'b1, 9'h007, 1'b0, 1'b0};
        vecs[6] = '{1, 9'h012, 1'b0, 1'b0, 1'b1, 1'b1, 9'h012, 1'b1, 1'b0};
        vecs[7] = '{1, 9'h06B, 1'b0, 1'b1, 1'b1, 1'b1, 9'h06B, 1'b0, 1'b1};

        rxd     = 2'b11;
        rxStart = 2'b11;
        #2 rst = 1'b0;
        #1;
        checkReset("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        for (int n = 0; n < 8; n++) begin
            v   = vecs[n];
            sel = v.sel;
            dw  = (sel == 0) ? 8 : 7;
            hp  = (sel == 0) ? 0 : 1;
            sc0 = storeCnt[sel];
            cc0 = clrCnt[sel];
            bh0 = busyHi[sel];
            rxStart[sel] = v.rxStart;
            sendWave(sel, mkFrame(v.data, dw, hp, v.parBit, v.stopBit), 2 + dw + hp, -1, 1000, t0);
            repeat (6) @(posedge clk);
            #1;
            rxStart[sel] = 1'b1;
            check($sformatf("v%0d store count", n), 32'(storeCnt[sel] - sc0),
                  v.expStore ? 32'd1 : 32'd0);
            if (v.expStore) begin
                check($sformatf("v%0d store cycle", n), 32'(storeAt[sel] - t0), 32'(155 + MAJ));
                check($sformatf("v%0d clr count", n), 32'(clrCnt[sel] - cc0), 32'd1);
                check($sformatf("v%0d clr cycle", n), 32'(clrAt[sel] - t0), 32'(156 + MAJ));
                check($sformatf("v%0d busy fall", n), 32'(busyFall[sel] - t0), 32'(157 + MAJ));
            end else begin
                check($sformatf("v%0d busy cycles", n), 32'(busyHi[sel] - bh0), 32'd0);
            end
            check($sformatf("v%0d rx_data", n), readData(sel), 32'(v.expData));
            check($sformatf("v%0d frame_err", n), 32'(feV[sel]), 32'(v.expFe));
            check($sformatf("v%0d parity_err", n), 32'(peV[sel]), 32'(v.expPe));
        end

        // Reset in the middle of data bit 2, then a clean frame.
        sendWave(0, mkFrame(9'h081, 8, 0, 1'b0, 1'b1), 10, -1, 56, t0);
        check("midframe busy", 32'(busyV[0]), 32'h1);
        rst = 1'b0;
        #1;
        checkReset("midframe reset");
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        sc0 = storeCnt[0];
        sendWave(0, mkFrame(9'h0C3, 8, 0, 1'b0, 1'b1), 10, -1, 1000, t0);
        repeat (6) @(posedge clk);
        #1;
        check("post-reset store count", 32'(storeCnt[0] - sc0), 32'd1);
        check("post-reset store cycle", 32'(storeAt[0] - t0), 32'(155 + MAJ));
        check("post-reset rx_data", 32'(rxData0), 32'h0C3);
        check("post-reset frame_err", 32'(feV[0]), 32'h0);

        // 4-cycle low glitch on an idle line: false start.
        sc0 = storeCnt[0];
        sendWave(0, 16'h0000, 1, -1, 4, t0);
        repeat (20) @(posedge clk);
        #1;
        check("glitch store count", 32'(storeCnt[0] - sc0), 32'd0);
        check("glitch busy rise", 32'(busyRise[0] - t0), 32'd3);
        check("glitch busy fall", 32'(busyFall[0] - t0), 32'(11 + MAJ));
        check("glitch rx_data", 32'(rxData0), 32'h0C3);

        // One-cycle high glitch at the centre of data bit 3 of 0x00.
        sc0 = storeCnt[0];
        sendWave(0, mkFrame(9'h000, 8, 0, 1'b0, 1'b1), 10, 72, 1000, t0);
        repeat (6) @(posedge clk);
        #1;
        check("centre glitch store count", 32'(storeCnt[0] - sc0), 32'd1);
        check("centre glitch store cycle", 32'(storeAt[0] - t0), 32'(155 + MAJ));
        check("centre glitch rx_data", 32'(rxData0), (MAJ != 0) ? 32'h00 : 32'h08);
        check("centre glitch frame_err", 32'(feV[0]), 32'h0);

        check("store/clr overlap", 32'(overlap), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
        $finish;
    end

endmodule
